pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

- Owns the program counter, instruction-fetch request and data-request sequencing for the MIPS core.
- Sits between the memory/cache arbiter and the control unit:
  - presents the held instruction word to the control unit;
  - consumes its decoded jump/branch/memory/halt signals and the ALU zero flag;
  - advances the PC one instruction at a time.
- Emits a one-cycle `retire` pulse that gates the register-file write enable.

## Interface
- `PC_INIT`, 32'h0000_0000, PC value loaded by reset
- `CLK` in 1, system clock, rising edge
- `RST` in 1, asynchronous, active-high reset
- `ihit` in 1, instruction memory returns valid `imemload` this cycle
- `dhit` in 1, data memory access completes this cycle
- `imemload` in 32, instruction word from memory
- `Jump`, `JAL`, `Jump2Reg`, `PCSrc`, `BNE`, `halt` in 1 each, control-unit decode of `inst`
- `dREN_req`, `dWEN_req` in 1 each, control-unit load/store decode of `inst`
- `zero` in 1, ALU zero flag
- `rdat1` in 32, register rs value, JR target
- `inst` out 32, instruction to the control unit
- `pc` out 32, current PC
- `pc_plus4` out 32, `pc`+4, JAL link value
- `iREN` out 1, instruction read request
- `dREN`, `dWEN` out 1 each, registered data requests
- `retire` out 1, current instruction completes this cycle
- `halted` out 1, sticky halt flag

## Operation
- FSM states and outputs:
  - FETCH: `iREN`=1; `inst`=`imemload`.
  - DATA: `iREN`=0; `inst`=latched word.
  - HALTED: `iREN`=0; all data requests 0.
- FETCH, `ihit`=0: hold.
- FETCH, `ihit`=1, `halt`=1: go to HALTED. `halted`<=1, `pc` held, `retire`=0.
- FETCH, `ihit`=1, no memory op: `retire`=1, `pc`<=next_pc, stay in FETCH.
- FETCH, `ihit`=1, `dREN_req`|`dWEN_req`:
  - latch `imemload` into the instruction register;
  - `dREN`<=`dREN_req`&~`dWEN_req`, `dWEN`<=`dWEN_req`;
  - go to DATA; `pc` held.
- DATA, `dhit`=0: hold requests.
- DATA, `dhit`=1: `retire`=1, `pc`<=next_pc, `dREN`/`dWEN`<=0, go to FETCH.
- HALTED: left only by reset.
- next_pc, priority order:
  1. `Jump2Reg`: `rdat1`.
  2. `Jump`: {`pc_plus4`[31:28], `inst`[25:0], 2'b00}.
  3. `PCSrc`&(`zero`^`BNE`): `pc_plus4` + (sign-extended `inst`[15:0] << 2).
  4. Otherwise `pc_plus4`.
- Arithmetic is 32-bit modulo. `pc`=32'hFFFF_FFFC advances to 32'h0000_0000.
- Ignored events: `dhit` in FETCH/HALTED; `ihit` in DATA/HALTED.
- Simultaneous `dREN_req` and `dWEN_req`: write wins, read suppressed.

## Timing
- Reset values:
  - `pc`=`PC_INIT`, state FETCH.
  - `dREN`=`dWEN`=0, `halted`=0, `retire`=0.
  - `iREN`=1 (combinational from FETCH); instruction register 0.
- `RST` mid-DATA clears requests and state immediately, without waiting for a clock edge.
- `retire`, `iREN`, `inst`, `pc_plus4` are combinational from state and inputs. `pc`, `dREN`, `dWEN`, `halted` are registered.
- Non-memory instruction: 1 cycle from `ihit` to PC update.
- Load/store: `dREN`/`dWEN` rise the edge after `ihit` and fall the edge after `dhit`. Minimum 2 cycles per instruction.
- `inst` is stable for the whole DATA residency.

## Configuration
- `PC_ALIGN_MASK_EN` defined: JR target is {`rdat1`[31:2], 2'b00}.
- Not defined: `rdat1` is used verbatim; misaligned PCs propagate.

## Structure
- Shared package `cpu_types_pkg` holds:
  - `word_t` (32-bit);
  - enum `fetch_state_t` {FETCH, DATA, HALTED};
  - constant `PC_RESET_DEFAULT`.
- Combinational sub-module `next_pc_calc` takes `pc_plus4`, `inst`, `rdat1`, `zero` and the control bits, and returns next_pc. It is unit-testable alone.

## Test plan
- Reset release, ADDI at 0x0, `ihit`=1: `retire`=1 for one cycle, `pc`=0x4 next edge, `dREN`=`dWEN`=0.
- LW at 0x8, `ihit`=1, `dhit` delayed 3 cycles:
  - `dREN`=1 for 4 cycles, `iREN`=0 throughout;
  - `pc` held at 0x8, `inst` stable;
  - after `dhit`, `pc`=0xC.
- BNE at 0x10, imm=0xFFFE, `zero`=0: `pc`=0x0C. Same with `zero`=1: `pc`=0x14.
- JR `rdat1`=0x0000_0103: `pc`=0x100 with `PC_ALIGN_MASK_EN`, 0x103 without. J at 0x4000_0000, target 0x10: `pc`=0x4000_0040.
- HALT fetched: `halted`=1 sticky, `iREN`=0, later `ihit`/`dhit` ignored. `RST` restores `pc`=`PC_INIT`, `halted`=0.
- `RST` pulsed mid-DATA between edges: `dWEN` falls asynchronously, state FETCH. `pc`=0xFFFF_FFFC retiring ADD: `pc`=0x0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS fetch path: word type, fetch FSM states and PC reset default.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned JIDX_W   = 26;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_RESET_DEFAULT = 32'h0000_0000;

    // Sign-extended branch immediate, already scaled to a byte offset.
    function automatic word_t branch_offset(input logic [IMM_W-1:0] imm);
        return {{(WORD_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: JR, J/JAL, taken branch, else sequential.
// Build option: PC_ALIGN_MASK_EN forces JR targets onto a word boundary.
module next_pc_calc
    import cpu_types_pkg::*;
(
    input  word_t                    pc_plus4,
    input  logic [JIDX_W-1:0]        inst,      // jump-index field; low 16 bits are the branch immediate
    input  word_t                    rdat1,
    input  logic                     zero,
    input  logic                     Jump,
    input  logic                     JAL,
    input  logic                     Jump2Reg,
    input  logic                     PCSrc,
    input  logic                     BNE,
    output word_t                    next_pc
);

    word_t jr_target;
    word_t jump_target;
    word_t branch_target;
    logic  branch_taken;

`ifdef PC_ALIGN_MASK_EN
    assign jr_target = rdat1 & ~word_t'(3);
`else
    assign jr_target = rdat1;
`endif

    assign jump_target   = {pc_plus4[WORD_W-1:WORD_W-4], inst, 2'b00};
    assign branch_target = pc_plus4 + branch_offset(inst[IMM_W-1:0]);
    assign branch_taken  = PCSrc & (zero ^ BNE);

    // JAL is a jump that also links, so it takes the jump target as well.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump2Reg) begin
            next_pc = jr_target;
        end else if (Jump | JAL) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction fetch and data-request sequencing for the MIPS core.
// Build option: PC_ALIGN_MASK_EN (see next_pc_calc) word-aligns JR targets.
module pc_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = PC_RESET_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  word_t       imemload,
    input  logic        Jump,
    input  logic        JAL,
    input  logic        Jump2Reg,
    input  logic        PCSrc,
    input  logic        BNE,
    input  logic        halt,
    input  logic        dREN_req,
    input  logic        dWEN_req,
    input  logic        zero,
    input  word_t       rdat1,
    output word_t       inst,
    output word_t       pc,
    output word_t       pc_plus4,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        retire,
    output logic        halted
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        ir_q, ir_d;
    logic         dren_q, dren_d;
    logic         dwen_q, dwen_d;
    logic         halted_q, halted_d;
    word_t        next_pc;

    // Fetch shows the live memory word; otherwise the latched word is held steady.
    assign inst     = (state_q == FETCH) ? imemload : ir_q;
    assign iREN     = (state_q == FETCH);
    assign pc_plus4 = pc_q + word_t'(4);

    assign pc     = pc_q;
    assign dREN   = dren_q;
    assign dWEN   = dwen_q;
    assign halted = halted_q;

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .inst     (inst[JIDX_W-1:0]),
        .rdat1    (rdat1),
        .zero     (zero),
        .Jump     (Jump),
        .JAL      (JAL),
        .Jump2Reg (Jump2Reg),
        .PCSrc    (PCSrc),
        .BNE      (BNE),
        .next_pc  (next_pc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= FETCH;
            pc_q     <= PC_INIT;
            ir_q     <= '0;
            dren_q   <= 1'b0;
            dwen_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            dren_q   <= dren_d;
            dwen_q   <= dwen_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        dren_d   = dren_q;
        dwen_d   = dwen_q;
        halted_d = halted_q;
        retire   = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (ihit) begin
                    if (halt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                        ir_d     = imemload;
                    end else if (dREN_req | dWEN_req) begin
                        // A store wins when both requests are decoded.
                        state_d = DATA;
                        ir_d    = imemload;
                        dren_d  = dREN_req & ~dWEN_req;
                        dwen_d  = dWEN_req;
                    end else begin
                        retire = 1'b1;
                        pc_d   = next_pc;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                    pc_d    = next_pc;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                end
            end
            HALTED: begin
                dren_d = 1'b0;
                dwen_d = 1'b0;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: next-PC vector table plus load/store, halt and reset sequences.
module tb_pc_fetch_unit;
    import cpu_types_pkg::*;

    logic  CLK, RST, ihit, dhit;
    word_t imemload, rdat1;
    logic  Jump, JAL, Jump2Reg, PCSrc, BNE, halt, dREN_req, dWEN_req, zero;
    word_t inst, pc, pc_plus4;
    logic  iREN, dREN, dWEN, retire, halted;

    pc_fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .imemload(imemload),
        .Jump(Jump), .JAL(JAL), .Jump2Reg(Jump2Reg), .PCSrc(PCSrc), .BNE(BNE),
        .halt(halt), .dREN_req(dREN_req), .dWEN_req(dWEN_req), .zero(zero),
        .rdat1(rdat1), .inst(inst), .pc(pc), .pc_plus4(pc_plus4), .iREN(iREN),
        .dREN(dREN), .dWEN(dWEN), .retire(retire), .halted(halted)
    );

`ifdef PC_ALIGN_MASK_EN
    localparam word_t JR_EXP = 32'h0000_0100;
`else
    localparam word_t JR_EXP = 32'h0000_0103;
`endif

    localparam word_t LW_WORD = 32'h8C22_0004;
    localparam word_t SW_WORD = 32'hAC22_0004;

    typedef struct {
        string name;
        logic  jump, jal, j2r, pcsrc, bne, zero;
        word_t iw, rdat1, start_pc, exp_pc;
    } vec_t;

    vec_t  vecs[11];
    word_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ihit = 0; dhit = 0; imemload = '0; rdat1 = '0;
        Jump = 0; JAL = 0; Jump2Reg = 0; PCSrc = 0; BNE = 0; halt = 0;
        dREN_req = 0; dWEN_req = 0; zero = 0;
    endtask

    // Expected PC goes in when the edge is launched and is popped once the DUT has updated.
    task automatic step_pc(input string name, input word_t exp_pc);
        exp_q.push_back(exp_pc);
        @(posedge CLK); #1;
        check({name, " pc"}, pc, exp_q.pop_front());
    endtask

    task automatic set_pc(input word_t target);
        clear_inputs();
        Jump2Reg = 1; rdat1 = target; ihit = 1; imemload = 32'h0000_0008;
        step_pc("set_pc", target);
        clear_inputs();
    endtask

    function automatic vec_t mk(input string n, input logic j, input logic jl, input logic jr,
                                input logic ps, input logic bn, input logic z,
                                input word_t iw, input word_t r1, input word_t sp, input word_t ep);
        vec_t v;
        v.name = n; v.jump = j; v.jal = jl; v.j2r = jr; v.pcsrc = ps; v.bne = bn; v.zero = z;
        v.iw = iw; v.rdat1 = r1; v.start_pc = sp; v.exp_pc = ep;
        return v;
    endfunction

    initial begin
        //           name          J  JAL JR PCS BNE Z  iw            rdat1         start         expected
        vecs[0]  = mk("addi",      0, 0,  0, 0,  0,  0, 32'h2001_0005, 32'h0,        32'h0000_0000, 32'h0000_0004);
        vecs[1]  = mk("bne_taken", 0, 0,  0, 1,  1,  0, 32'h1422_FFFE, 32'h0,        32'h0000_0010, 32'h0000_000C);
        vecs[2]  = mk("bne_not",   0, 0,  0, 1,  1,  1, 32'h1422_FFFE, 32'h0,        32'h0000_0010, 32'h0000_0014);
        vecs[3]  = mk("beq_taken", 0, 0,  0, 1,  0,  1, 32'h1022_0004, 32'h0,        32'h0000_0020, 32'h0000_0034);
        vecs[4]  = mk("beq_not",   0, 0,  0, 1,  0,  0, 32'h1022_0004, 32'h0,        32'h0000_0020, 32'h0000_0024);
        vecs[5]  = mk("j_region",  1, 0,  0, 0,  0,  0, 32'h0800_0010, 32'h0,        32'h4000_0000, 32'h4000_0040);
        vecs[6]  = mk("jr_misal",  0, 0,  1, 0,  0,  0, 32'h03E0_0008, 32'h0000_0103, 32'h0000_0040, JR_EXP);
        vecs[7]  = mk("jr_over_j", 1, 0,  1, 0,  0,  0, 32'h0800_0020, 32'h0000_0200, 32'h0000_0060, 32'h0000_0200);
        vecs[8]  = mk("j_over_br", 1, 0,  0, 1,  0,  1, 32'h0800_0020, 32'h0,        32'h0000_0100, 32'h0000_0080);
        vecs[9]  = mk("add_wrap",  0, 0,  0, 0,  0,  0, 32'h0022_1820, 32'h0,        32'hFFFF_FFFC, 32'h0000_0000);
        vecs[10] = mk("jal",       1, 1,  0, 0,  0,  0, 32'h0C00_0004, 32'h0,        32'h0000_0050, 32'h0000_0010);

        clear_inputs();
        RST = 1;

        // Reset state, then ihit low holds and a stray dhit is ignored.
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        #1;
        check("rst pc", pc, 32'h0);
        check("rst dREN", word_t'(dREN), 32'h0);
        check("rst dWEN", word_t'(dWEN), 32'h0);
        check("rst halted", word_t'(halted), 32'h0);
        check("rst retire", word_t'(retire), 32'h0);
        check("rst iREN", word_t'(iREN), 32'h1);
        check("rst inst", inst, 32'h0);
        dhit = 1;
        step_pc("hold", 32'h0);
        check("hold dREN", word_t'(dREN), 32'h0);
        clear_inputs();

        // Single-cycle instructions: next-PC selection.
        for (int i = 0; i < 11; i++) begin
            set_pc(vecs[i].start_pc);
            Jump = vecs[i].jump; JAL = vecs[i].jal; Jump2Reg = vecs[i].j2r;
            PCSrc = vecs[i].pcsrc; BNE = vecs[i].bne; zero = vecs[i].zero;
            imemload = vecs[i].iw; rdat1 = vecs[i].rdat1; ihit = 1;
            #3;
            check({vecs[i].name, " retire"}, word_t'(retire), 32'h1);
            check({vecs[i].name, " iREN"}, word_t'(iREN), 32'h1);
            check({vecs[i].name, " inst"}, inst, vecs[i].iw);
            check({vecs[i].name, " pc_plus4"}, pc_plus4, vecs[i].start_pc + 32'd4);
            step_pc(vecs[i].name, vecs[i].exp_pc);
            check({vecs[i].name, " dREN"}, word_t'(dREN), 32'h0);
            check({vecs[i].name, " dWEN"}, word_t'(dWEN), 32'h0);
            clear_inputs();
        end

        // Load at 0x8 with dhit three cycles late; ihit during DATA is ignored.
        set_pc(32'h8);
        ihit = 1; dREN_req = 1; imemload = LW_WORD;
        #3;
        check("lw fetch retire", word_t'(retire), 32'h0);
        step_pc("lw issue", 32'h8);
        imemload = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            check("lw dREN", word_t'(dREN), 32'h1);
            check("lw dWEN", word_t'(dWEN), 32'h0);
            check("lw iREN", word_t'(iREN), 32'h0);
            check("lw inst", inst, LW_WORD);
            check("lw retire", word_t'(retire), 32'h0);
            step_pc("lw wait", 32'h8);
        end
        check("lw last dREN", word_t'(dREN), 32'h1);
        dhit = 1;
        #1;
        check("lw dhit retire", word_t'(retire), 32'h1);
        step_pc("lw done", 32'hC);
        check("lw done dREN", word_t'(dREN), 32'h0);
        check("lw done iREN", word_t'(iREN), 32'h1);
        clear_inputs();

        // Both requests: write wins. Then reset between edges drops dWEN at once.
        set_pc(32'h20);
        ihit = 1; dREN_req = 1; dWEN_req = 1; imemload = SW_WORD;
        step_pc("sw issue", 32'h20);
        check("sw dWEN", word_t'(dWEN), 32'h1);
        check("sw dREN", word_t'(dREN), 32'h0);
        ihit = 0;
        #3 RST = 1;
        #1;
        check("async rst dWEN", word_t'(dWEN), 32'h0);
        check("async rst iREN", word_t'(iREN), 32'h1);
        check("async rst pc", pc, 32'h0);
        #1 RST = 0;
        clear_inputs();
        @(posedge CLK); #1;

        // Halt is sticky; later hits and requests are ignored until reset.
        set_pc(32'h30);
        ihit = 1; halt = 1; imemload = 32'hFC00_0000;
        #3;
        check("halt retire", word_t'(retire), 32'h0);
        step_pc("halt", 32'h30);
        check("halt flag", word_t'(halted), 32'h1);
        check("halt iREN", word_t'(iREN), 32'h0);
        halt = 0; dhit = 1; dREN_req = 1; Jump = 1; imemload = 32'h0800_0004;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("halted retire", word_t'(retire), 32'h0);
            step_pc("halted hold", 32'h30);
            check("halted flag", word_t'(halted), 32'h1);
            check("halted dREN", word_t'(dREN), 32'h0);
            check("halted iREN", word_t'(iREN), 32'h0);
        end
        clear_inputs();
        #2 RST = 1;
        #1;
        check("halt rst pc", pc, 32'h0);
        check("halt rst flag", word_t'(halted), 32'h0);
        check("halt rst iREN", word_t'(iREN), 32'h1);
        #1 RST = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
